tstate_sequencer: RTL and testbench
===================================

// Module: tstate_sequencer
// PURPOSE
//  - Generates the one-hot T-state (T1,T2,Tw1,Tw2,T3,T4,T5,T6) and M-cycle (M1..M6) timing for the control unit.
//  - Sits directly upstream of pin_control: drives its T1..T4/Tw1/Tw2/setM1 inputs and consumes its hold_clk_timing.
//  - T-state count per M-cycle is selected by the current function (fFetch..fIOWrite) and in_intr.
//  - Decode supplies last_mcycle, which marks the final M-cycle of an instruction.
// PARAMETERS
//  - NUM_M     default 6  number of M-cycle one-hot outputs; max M-cycles per instruction
//  - T_EXT_MAX default 2  max extra T-states (T5,T6) appended after T4; only used with TSEQ_T_EXTEND_EN
// PORTS
//  - clk             in   1      single clock; all state changes on posedge
//  - reset           in   1      synchronous, active-high
//  - hold_clk_timing in   1      from pin_control (WAIT/BUSRQ); freezes the sequencer
//  - fFetch          in   1      function: opcode fetch
//  - fMRead          in   1      function: memory read
//  - fMWrite         in   1      function: memory write
//  - fIORead         in   1      function: IO read
//  - fIOWrite        in   1      function: IO write
//  - in_intr         in   1      interrupt acknowledge fetch (inserts Tw1,Tw2)
//  - last_mcycle     in   1      current M-cycle is the last of the instruction
//  - t_ext           in   2      extra T-states after T4 (0..T_EXT_MAX)
//  - T1,T2,Tw1,Tw2,T3,T4,T5,T6  out  1 each  one-hot T-state (registered)
//  - M               out  NUM_M  one-hot M-cycle; M[0]=M1 (registered)
//  - setM1           out  1      last T-state of last M-cycle (decoded from registers)
//  - mcycle_end      out  1      last T-state of any M-cycle
//  - mcyc_ovf        out  1      sticky: M-cycle count exceeded NUM_M
// BEHAVIOUR
//  - Reset (sync, overrides hold): T1=1, M[0]=1; all other T/M outputs, setM1, mcycle_end, mcyc_ovf = 0.
//  - Function priority if several are set: Fetch > MRead > MWrite > IORead > IOWrite.
//  - If no function is set, the M-cycle is a 3-T internal cycle with MRead timing.
//  - Function inputs must remain stable for the whole M-cycle.
//  - T-state transitions, one clk per state:
//    - T1 -> T2.
//    - T2 -> Tw1 if fFetch&in_intr, else T3.
//    - Tw1 -> Tw2 -> T3.
//    - T3 -> end for MRead/MWrite/internal cycles; otherwise T3 -> T4.
//    - T4 -> T5 if extension is active (see CONFIGURATION), else end.
//    - T5 -> T6 if t_ext==2, else end; T6 -> end.
//  - End of M-cycle: mcycle_end=1 during the final T-state; next state is T1.
//    - If last_mcycle: M returns to M1.
//    - Otherwise M shifts left by one.
//  - setM1 = mcycle_end & last_mcycle.
//  - M wrap: if not last_mcycle at the end of M[NUM_M-1], M wraps to M1 and mcyc_ovf sets. mcyc_ovf is cleared only by reset.
//  - Hold: while hold_clk_timing=1 at a posedge, the T and M registers keep their values.
//    - All outputs stay constant during hold, including setM1/mcycle_end, which remain asserted if already high.
//    - Release: advances normally on the first posedge with hold=0. Hold in T1 is legal and freezes T1.
//  - Latency: N-T cycle takes exactly N clocks with hold low: Fetch 4 (6 with in_intr), MRead/MWrite 3, IO 4.
//  - Reset mid-cycle: next posedge forces T1/M1 irrespective of state, hold or t_ext.
// CONFIGURATION
//  - TSEQ_T_EXTEND_EN defined:
//    - t_ext is honoured for Fetch cycles only; values above T_EXT_MAX saturate.
//    - Gives 5/6-T fetches (e.g. INC rr, PUSH).
//  - TSEQ_T_EXTEND_EN undefined:
//    - t_ext port kept but ignored; T5 and T6 tied to 0; T4 always ends the cycle.
// STRUCTURE
//  - tseq_pkg: enum tstate_e {TS_T1,TS_T2,TS_TW1,TS_TW2,TS_T3,TS_T4,TS_T5,TS_T6}.
//  - tseq_pkg: localparams for base T-count per function; function-select priority encode function.
//  - State register is a one-hot tstate_e; outputs are direct register bits.
//  - Sub-module mcycle_ring: NUM_M one-hot shift ring with advance/restart/hold inputs and ovf output.
// TESTING
//  - reset, fFetch, in_intr=0, last_mcycle=1
//    -> T1,T2,T3,T4 one clk each; setM1 only in T4; then T1 with M=000001.
//  - fFetch, in_intr=1
//    -> T1,T2,Tw1,Tw2,T3,T4 (6 clks); Tw1/Tw2 each high 1 clk; setM1 in T4.
//  - M1 fetch (last_mcycle=0), then fMRead with last_mcycle=1
//    -> M=000010 for T1..T3; setM1 at clk 7; clk 8 is T1/M1.
//  - fMRead, hold_clk_timing=1 for 3 clks starting in T2
//    -> T2 high 4 clks; M-cycle lasts 6 clks; no other output toggles during hold.
//  - reset asserted during T3 of M2 with hold=1
//    -> next clk T1=1, M=000001, setM1=0, mcyc_ovf=0.
//  - TSEQ_T_EXTEND_EN, fFetch, t_ext=2
//    -> T1..T4,T5,T6; setM1 in T6.
//  - Same stimulus, macro undefined
//    -> 4 clks; T5/T6 never high.
//  - 7 M-cycles with last_mcycle=0 (NUM_M=6)
//    -> wrap to M1 after M6; mcyc_ovf=1 until reset.

Source files
------------

// File: rtl/tseq_pkg.sv
// ---------------------------------------------------------------------------
// tseq_pkg
// Shared types and helpers for the T-state / M-cycle sequencer.
//   tstate_e     : one-hot T-state encoding; bit order T1,T2,Tw1,Tw2,T3,T4,T5,T6
//   func_e       : resolved bus function for the current M-cycle
//   TCNT_*       : base T-state count per function (no wait states, no extension)
//   func_select  : priority encode of the function inputs
//   base_tcount  : base T-count for a resolved function
// ---------------------------------------------------------------------------
package tseq_pkg;

    typedef enum logic [7:0] {
        TS_T1  = 8'b0000_0001,
        TS_T2  = 8'b0000_0010,
        TS_TW1 = 8'b0000_0100,
        TS_TW2 = 8'b0000_1000,
        TS_T3  = 8'b0001_0000,
        TS_T4  = 8'b0010_0000,
        TS_T5  = 8'b0100_0000,
        TS_T6  = 8'b1000_0000
    } tstate_e;

    typedef enum logic [2:0] {
        FN_FETCH,
        FN_MREAD,
        FN_MWRITE,
        FN_IOREAD,
        FN_IOWRITE,
        FN_INTERNAL
    } func_e;

    localparam int unsigned TCNT_FETCH    = 4;
    localparam int unsigned TCNT_MEM      = 3;
    localparam int unsigned TCNT_IO       = 4;
    localparam int unsigned TCNT_INTERNAL = 3;

    // Fetch > MRead > MWrite > IORead > IOWrite; nothing set is an internal cycle.
    function automatic func_e func_select(input logic f_fetch, input logic f_mread,
                                          input logic f_mwrite, input logic f_ioread,
                                          input logic f_iowrite);
        func_e f;
        if (f_fetch)        f = FN_FETCH;
        else if (f_mread)   f = FN_MREAD;
        else if (f_mwrite)  f = FN_MWRITE;
        else if (f_ioread)  f = FN_IOREAD;
        else if (f_iowrite) f = FN_IOWRITE;
        else                f = FN_INTERNAL;
        return f;
    endfunction

    function automatic int unsigned base_tcount(input func_e f);
        int unsigned n;
        case (f)
            FN_FETCH:              n = TCNT_FETCH;
            FN_MREAD, FN_MWRITE:   n = TCNT_MEM;
            FN_IOREAD, FN_IOWRITE: n = TCNT_IO;
            default:               n = TCNT_INTERNAL;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tstate_sequencer_mcycle_ring.sv
// ---------------------------------------------------------------------------
// mcycle_ring
// One-hot M-cycle ring. Bit 0 is M1.
//   clk_i      : clock
//   reset_i    : synchronous active-high reset (overrides hold)
//   hold_i     : freeze the ring
//   advance_i  : current M-cycle is in its final T-state
//   restart_i  : return to M1 on advance (last M-cycle of the instruction)
//   m_o        : one-hot M-cycle
//   ovf_o      : sticky, set when the ring wraps past the top M-cycle
// ---------------------------------------------------------------------------
module mcycle_ring #(
    parameter int NUM_M = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             hold_i,
    input  logic             advance_i,
    input  logic             restart_i,
    output logic [NUM_M-1:0] m_o,
    output logic             ovf_o
);

    logic [NUM_M-1:0] m_q, m_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        m_d   = m_q;
        ovf_d = ovf_q;
        if (advance_i && !hold_i) begin
            if (restart_i) begin
                m_d = NUM_M'(1);
            end else if (m_q[NUM_M-1]) begin
                // Ran past the last M-cycle without decode marking the end.
                m_d   = NUM_M'(1);
                ovf_d = 1'b1;
            end else begin
                m_d = m_q << 1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            m_q   <= NUM_M'(1);
            ovf_q <= 1'b0;
        end else begin
            m_q   <= m_d;
            ovf_q <= ovf_d;
        end
    end

    assign m_o   = m_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/tstate_sequencer.sv
// ---------------------------------------------------------------------------
// tstate_sequencer
// One-hot T-state and M-cycle timing generator for the control unit.
// Optional feature macro: TSEQ_T_EXTEND_EN -- when defined, fetch cycles may
// append T5/T6 as selected by t_ext (saturated at T_EXT_MAX); when undefined,
// t_ext is ignored and T5/T6 stay low.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   hold_clk_timing     : freeze from pin_control (WAIT/BUSRQ)
//   fFetch..fIOWrite    : bus function of the current M-cycle
//   in_intr             : interrupt-acknowledge fetch (adds Tw1, Tw2)
//   last_mcycle         : current M-cycle is the instruction's last
//   t_ext               : extra T-states after T4 on fetch
//   T1,T2,Tw1,Tw2,T3..T6: registered one-hot T-state
//   M                   : registered one-hot M-cycle, M[0]=M1
//   setM1, mcycle_end   : final T-state of last / any M-cycle
//   mcyc_ovf            : sticky M-cycle ring overflow
// ---------------------------------------------------------------------------
module tstate_sequencer
    import tseq_pkg::*;
#(
    parameter int NUM_M     = 6,
    parameter int T_EXT_MAX = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold_clk_timing,
    input  logic             fFetch,
    input  logic             fMRead,
    input  logic             fMWrite,
    input  logic             fIORead,
    input  logic             fIOWrite,
    input  logic             in_intr,
    input  logic             last_mcycle,
    input  logic [1:0]       t_ext,
    output logic             T1,
    output logic             T2,
    output logic             Tw1,
    output logic             Tw2,
    output logic             T3,
    output logic             T4,
    output logic             T5,
    output logic             T6,
    output logic [NUM_M-1:0] M,
    output logic             setM1,
    output logic             mcycle_end,
    output logic             mcyc_ovf
);

`ifdef TSEQ_T_EXTEND_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    func_e    fn;
    logic     short_cyc;
    logic [1:0] ext_sat;
    logic     ext_t5, ext_t6;
    tstate_e  state_q;

    assign fn        = func_select(fFetch, fMRead, fMWrite, fIORead, fIOWrite);
    assign short_cyc = (base_tcount(fn) == 3);

    // Extension only applies to fetch; anything above T_EXT_MAX saturates.
    always_comb begin
        ext_sat = t_ext;
        if (int'(t_ext) > T_EXT_MAX) ext_sat = 2'(T_EXT_MAX);
        if (!EXT_EN || fn != FN_FETCH) ext_sat = 2'd0;
    end

    assign ext_t5 = (ext_sat >= 2'd1);
    assign ext_t6 = (ext_sat >= 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TS_T1;
        end else if (!hold_clk_timing) begin
            case (state_q)
                TS_T1:  state_q <= TS_T2;
                TS_T2:  if (fn == FN_FETCH && in_intr) state_q <= TS_TW1;
                        else                           state_q <= TS_T3;
                TS_TW1: state_q <= TS_TW2;
                TS_TW2: state_q <= TS_T3;
                TS_T3:  if (short_cyc) state_q <= TS_T1;
                        else           state_q <= TS_T4;
                TS_T4:  if (ext_t5) state_q <= TS_T5;
                        else        state_q <= TS_T1;
                TS_T5:  if (ext_t6) state_q <= TS_T6;
                        else        state_q <= TS_T1;
                default: state_q <= TS_T1;
            endcase
        end
    end

    // Decoded from the held state plus the (stable) function inputs, so it
    // stays asserted across a hold.
    always_comb begin
        mcycle_end = 1'b0;
        case (state_q)
            TS_T3:   mcycle_end = short_cyc;
            TS_T4:   mcycle_end = !ext_t5;
            TS_T5:   mcycle_end = !ext_t6;
            TS_T6:   mcycle_end = 1'b1;
            default: mcycle_end = 1'b0;
        endcase
    end

    assign setM1 = mcycle_end & last_mcycle;

    assign T1  = state_q[0];
    assign T2  = state_q[1];
    assign Tw1 = state_q[2];
    assign Tw2 = state_q[3];
    assign T3  = state_q[4];
    assign T4  = state_q[5];
    assign T5  = EXT_EN & state_q[6];
    assign T6  = EXT_EN & state_q[7];

    mcycle_ring #(.NUM_M(NUM_M)) u_ring (
        .clk_i     (clk),
        .reset_i   (reset),
        .hold_i    (hold_clk_timing),
        .advance_i (mcycle_end),
        .restart_i (last_mcycle),
        .m_o       (M),
        .ovf_o     (mcyc_ovf)
    );

endmodule

// File: tb/tb_tstate_sequencer.sv
module tb_tstate_sequencer;

`ifdef TSEQ_T_EXTEND_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    localparam logic [7:0] S1 = 8'h01, S2 = 8'h02, SW1 = 8'h04, SW2 = 8'h08,
                           S3 = 8'h10, S4 = 8'h20, S5 = 8'h40, S6 = 8'h80;

    logic clk = 1'b0;
    logic reset, hold, ff, fr, fw, ior, iow, intr, last;
    logic [1:0] text;
    logic T1, T2, Tw1, Tw2, T3, T4, T5, T6, setM1, mend, ovf;
    logic [5:0] M;

    always #5 clk = ~clk;

    tstate_sequencer dut (
        .clk(clk), .reset(reset), .hold_clk_timing(hold),
        .fFetch(ff), .fMRead(fr), .fMWrite(fw), .fIORead(ior), .fIOWrite(iow),
        .in_intr(intr), .last_mcycle(last), .t_ext(text),
        .T1(T1), .T2(T2), .Tw1(Tw1), .Tw2(Tw2), .T3(T3), .T4(T4), .T5(T5), .T6(T6),
        .M(M), .setM1(setM1), .mcycle_end(mend), .mcyc_ovf(ovf)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] tvec();
        return {T6, T5, T4, T3, Tw2, Tw1, T2, T1};
    endfunction

    function automatic logic [31:0] obs();
        return {15'd0, tvec(), M, mend, setM1, ovf};
    endfunction

    typedef struct {
        logic       rst, hld, f, r, in, lst;
        logic [7:0] t;
        logic [5:0] m;
        logic       en, s1, ov;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, hld, f, r, in, lst,
                               input logic [7:0] t, input logic [5:0] m,
                               input logic en, s1, ov);
        vec_t x;
        x.rst = rst; x.hld = hld; x.f = f; x.r = r; x.in = in; x.lst = lst;
        x.t = t; x.m = m; x.en = en; x.s1 = s1; x.ov = ov;
        return x;
    endfunction

    task automatic drive(input logic rst, hld, f, r, in, lst);
        reset = rst; hold = hld; ff = f; fr = r; fw = 1'b0; ior = 1'b0; iow = 1'b0;
        intr = in; last = lst; text = 2'd0;
    endtask

    // ---------------- reference model ----------------
    int   pos, mi;
    logic movf;
    logic [7:0] seq[$];

    function automatic void build_seq();
        int n;
        bit fetch, io;
        fetch = ff;
        io    = !ff && !fr && !fw && (ior || iow);
        seq.delete();
        seq.push_back(S1);
        seq.push_back(S2);
        if (fetch && intr) begin
            seq.push_back(SW1);
            seq.push_back(SW2);
        end
        seq.push_back(S3);
        if (fetch || io) seq.push_back(S4);
        if (EXT && fetch) begin
            n = (text > 2) ? 2 : int'(text);
            if (n >= 1) seq.push_back(S5);
            if (n >= 2) seq.push_back(S6);
        end
    endfunction

    function automatic void model_step();
        if (reset) begin
            pos = 0; mi = 0; movf = 1'b0;
        end else if (!hold) begin
            build_seq();
            if (pos == seq.size() - 1) begin
                pos = 0;
                if (last) mi = 0;
                else if (mi == 5) begin mi = 0; movf = 1'b1; end
                else mi++;
            end else begin
                pos++;
            end
        end
    endfunction

    function automatic logic [31:0] model_exp();
        logic e;
        build_seq();
        e = (pos == seq.size() - 1);
        return {15'd0, seq[pos], 6'(1 << mi), e, e & last, movf};
    endfunction

    initial begin
        int n;
        bit saw56;

        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // rst hold ff fr intr last | T M end setM1 ovf
        tbl.push_back(v(1,0,1,0,0,1, S1, 6'd1, 0,0,0));
        // plain fetch, last M-cycle
        tbl.push_back(v(0,0,1,0,0,1, S2, 6'd1, 0,0,0));
        tbl.push_back(v(0,0,1,0,0,1, S3, 6'd1, 0,0,0));
        tbl.push_back(v(0,0,1,0,0,1, S4, 6'd1, 1,1,0));
        tbl.push_back(v(0,0,1,0,0,1, S1, 6'd1, 0,0,0));
        // interrupt-acknowledge fetch
        tbl.push_back(v(0,0,1,0,1,1, S2, 6'd1, 0,0,0));
        tbl.push_back(v(0,0,1,0,1,1, SW1,6'd1, 0,0,0));
        tbl.push_back(v(0,0,1,0,1,1, SW2,6'd1, 0,0,0));
        tbl.push_back(v(0,0,1,0,1,1, S3, 6'd1, 0,0,0));
        tbl.push_back(v(0,0,1,0,1,1, S4, 6'd1, 1,1,0));
        tbl.push_back(v(0,0,1,0,1,1, S1, 6'd1, 0,0,0));
        // M1 fetch not last, then M2 read that is last
        tbl.push_back(v(0,0,1,0,0,0, S2, 6'd1, 0,0,0));
        tbl.push_back(v(0,0,1,0,0,0, S3, 6'd1, 0,0,0));
        tbl.push_back(v(0,0,1,0,0,0, S4, 6'd1, 1,0,0));
        tbl.push_back(v(0,0,1,0,0,0, S1, 6'd2, 0,0,0));
        tbl.push_back(v(0,0,0,1,0,1, S2, 6'd2, 0,0,0));
        tbl.push_back(v(0,0,0,1,0,1, S3, 6'd2, 1,1,0));
        tbl.push_back(v(0,0,0,1,0,1, S1, 6'd1, 0,0,0));
        // read with 3-clock hold in T2
        tbl.push_back(v(0,0,0,1,0,1, S2, 6'd1, 0,0,0));
        tbl.push_back(v(0,1,0,1,0,1, S2, 6'd1, 0,0,0));
        tbl.push_back(v(0,1,0,1,0,1, S2, 6'd1, 0,0,0));
        tbl.push_back(v(0,1,0,1,0,1, S2, 6'd1, 0,0,0));
        tbl.push_back(v(0,0,0,1,0,1, S3, 6'd1, 1,1,0));
        tbl.push_back(v(0,0,0,1,0,1, S1, 6'd1, 0,0,0));
        // reset during T3 of M2 while held
        tbl.push_back(v(0,0,1,0,0,0, S2, 6'd1, 0,0,0));
        tbl.push_back(v(0,0,1,0,0,0, S3, 6'd1, 0,0,0));
        tbl.push_back(v(0,0,1,0,0,0, S4, 6'd1, 1,0,0));
        tbl.push_back(v(0,0,1,0,0,0, S1, 6'd2, 0,0,0));
        tbl.push_back(v(0,0,0,1,0,0, S2, 6'd2, 0,0,0));
        tbl.push_back(v(0,0,0,1,0,0, S3, 6'd2, 1,0,0));
        tbl.push_back(v(1,1,0,1,0,0, S1, 6'd1, 0,0,0));
        // hold on the final T-state keeps setM1/mcycle_end high
        tbl.push_back(v(0,0,0,1,0,1, S2, 6'd1, 0,0,0));
        tbl.push_back(v(0,0,0,1,0,1, S3, 6'd1, 1,1,0));
        tbl.push_back(v(0,1,0,1,0,1, S3, 6'd1, 1,1,0));
        tbl.push_back(v(0,0,0,1,0,1, S1, 6'd1, 0,0,0));

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].hld, tbl[i].f, tbl[i].r, tbl[i].in, tbl[i].lst);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d", i), obs(),
                {15'd0, tbl[i].t, tbl[i].m, tbl[i].en, tbl[i].s1, tbl[i].ov});
        end

        // 7 read M-cycles, never last: wraps after M6 and sets overflow
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk($sformatf("wrap_m%0d", k), {26'd0, M}, 32'(1 << (k % 6)));
            chk($sformatf("wrap_ovf%0d", k), {31'd0, ovf}, {31'd0, k >= 6});
        end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ovf_cleared", {25'd0, ovf, M}, 32'd1);
        reset = 1'b0;

        // fetch with oversized extension request
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        text = 2'd3;
        n = 0;
        saw56 = 1'b0;
        do begin
            @(posedge clk); @(negedge clk);
            n++;
            if (T5 || T6) saw56 = 1'b1;
            if (T6) chk("ext_setm1_t6", {31'd0, setM1}, 32'd1);
        end while (!T1 && n < 20);
        chk("ext_len", n, EXT ? 32'd6 : 32'd4);
        chk("ext_t56_seen", {31'd0, saw56}, {31'd0, EXT});

        // randomized run against the reference model
        reset = 1'b1;
        @(posedge clk);
        pos = 0; mi = 0; movf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            chk($sformatf("rand%0d", c), obs(), model_exp());
            hold  = ($urandom_range(3) == 0);
            reset = ($urandom_range(63) == 0);
            if (pos == 0) begin
                {ff, fr, fw, ior, iow} = 5'($urandom_range(31));
                if ($urandom_range(3) == 0) ff = 1'b1;
                if ($urandom_range(5) == 0) {ff, fr, fw, ior, iow} = 5'd0;
                intr = ($urandom_range(3) == 0);
                last = ($urandom_range(9) < 3);
                text = 2'($urandom_range(3));
            end
            model_step();
            @(posedge clk);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
